// File: rtl/filter_pixel_packer_if.sv
// Pixel stream from the 3x3 filter and packed 128-bit word stream
// toward the DRAM write master.
interface filter_pixel_packer_if;
    logic         WREN;
    logic [7:0]   IN_R;
    logic [7:0]   IN_G;
    logic [7:0]   IN_B;
    logic         PIX_READY;
    logic [127:0] OUT_DATA;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic         OUT_LAST;

    modport master (
        output WREN, IN_R, IN_G, IN_B, OUT_READY,
        input  PIX_READY, OUT_DATA, OUT_VALID, OUT_LAST
    );

    modport slave (
        input  WREN, IN_R, IN_G, IN_B, OUT_READY,
        output PIX_READY, OUT_DATA, OUT_VALID, OUT_LAST
    );
endinterface

// File: rtl/filter_pixel_packer.sv
// Packs 4 filter pixels per 128-bit word into a FWFT FIFO with frame
// markers and a registered almost-full backpressure flag.
module filter_pixel_packer #(
    parameter int IMG_W      = 5528,
    parameter int IMG_H      = 2200,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    filter_pixel_packer_if.slave bus,
    output logic                 FRAME_DONE,
    output logic                 OVERFLOW
);
    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int CW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIX - 1);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_LEVEL = (AW + 1)'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [1:0]       lane;
    logic [CW-1:0]    pix_cnt;
    logic [2:0][23:0] pack;
    logic [3:0][23:0] word;
    logic [23:0]      pixel;
    logic             last_pix;
    logic             push;
    logic             pop;
    logic             full;
    logic             valid;
    logic             do_push;

    // Entry layout: {last, lane3..lane0 RGB}; the zero pad byte is added on read.
    logic [96:0]   mem [FIFO_DEPTH];
    logic [96:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    assign pixel    = {bus.IN_R, bus.IN_G, bus.IN_B};
    assign last_pix = pix_cnt == LAST_PIX;
    assign push     = bus.WREN && (lane == 2'd3 || last_pix);

    // Lanes above the current pixel are zero so a short final word is padded.
    always_comb begin
        word = '0;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < lane) word[i] = pack[i];
        end
        word[lane] = pixel;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lane    <= '0;
            pix_cnt <= '0;
            pack    <= '0;
        end else if (bus.WREN) begin
            lane    <= push ? 2'd0 : lane + 2'd1;
            pix_cnt <= last_pix ? '0 : pix_cnt + CW'(1);
            for (int i = 0; i < 3; i++) begin
                if (!push && lane == 2'(i)) pack[i] <= pixel;
            end
        end
    end

    assign valid   = count != '0;
    assign full    = count == DEPTH;
    assign pop     = valid && bus.OUT_READY;
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !pop) count_next = count + ONE;
        else if (pop && !do_push) count_next = count - ONE;
    end

    always_ff @(posedge CLK) begin
        if (!RST && do_push) mem[wr_ptr] <= {last_pix, word};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.PIX_READY <= 1'b0;
            FRAME_DONE    <= 1'b0;
            OVERFLOW      <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count         <= count_next;
            bus.PIX_READY <= count_next <= AF_LEVEL;
            FRAME_DONE    <= pop && head[96];
            OVERFLOW      <= OVERFLOW | (push && full && !pop);
        end
    end

    always_comb begin
        bus.OUT_DATA = '0;
        if (valid) begin
            for (int i = 0; i < 4; i++) begin
                bus.OUT_DATA[32*i +: 32] = {8'h00, head[24*i +: 24]};
            end
        end
    end

    assign bus.OUT_VALID = valid;
    assign bus.OUT_LAST  = valid && head[96];
endmodule
